// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen: colour-bar background with a bouncing square sprite,
// drawn one clock behind the timing controller with syncs kept aligned.
module vga_pixel_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BOX_SIZE  = 32,
  parameter int unsigned STEP      = 2,
  parameter logic [7:0]  BOX_COLOR = 8'h92
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] rgb,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned POS_W = 11;
  localparam int unsigned RGB_W = 8;

  localparam logic [POS_W-1:0] BOX_W   = POS_W'(BOX_SIZE);
  localparam logic [POS_W-1:0] STEP_W  = POS_W'(STEP);
  localparam logic [POS_W-1:0] H_LIMIT = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_LIMIT = POS_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  // Motion direction per axis: forward is right (x) or down (y).
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // Output and sprite state.
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;
  logic [POS_W-1:0] box_x_q, box_x_d;
  logic [POS_W-1:0] box_y_q, box_y_d;
  dir_e             dir_x_q, dir_x_d;
  dir_e             dir_y_q, dir_y_d;

  // Pixel classification signals.
  logic [POS_W-1:0] hpos_c;
  logic [POS_W-1:0] vpos_c;
  logic             active_c;
  logic             hit_x_c;
  logic             hit_y_c;
  logic             hit_c;
  logic [RGB_W-1:0] bar_color_c;
  logic             tick_cond_c;

  // Widen counters so sprite bounds near the right edge cannot wrap.
  always_comb begin
    hpos_c      = POS_W'(hcount);
    vpos_c      = POS_W'(vcount);
    active_c    = (hcount < H_ACT_C) && (vcount < V_ACT_C);
    hit_x_c     = (hpos_c >= box_x_q) && (hpos_c < (box_x_q + BOX_W));
    hit_y_c     = (vpos_c >= box_y_q) && (vpos_c < (box_y_q + BOX_W));
    hit_c       = hit_x_c && hit_y_c;
    tick_cond_c = (hcount == '0) && (vcount == V_ACT_C);
  end

  // 64-pixel bars; index taken from hcount[8:6] so bars 8 and 9 repeat 0 and 1.
  always_comb begin
    bar_color_c = 8'h00;
    case (hcount[8:6])
      3'd0:    bar_color_c = 8'hFF;
      3'd1:    bar_color_c = 8'hFC;
      3'd2:    bar_color_c = 8'h1F;
      3'd3:    bar_color_c = 8'h1C;
      3'd4:    bar_color_c = 8'hE3;
      3'd5:    bar_color_c = 8'hE0;
      3'd6:    bar_color_c = 8'h03;
      default: bar_color_c = 8'h00;
    endcase
  end

  // Colour priority: blanking, then sprite, then bar; syncs ride alongside.
  always_comb begin
    rgb_d        = '0;
    hsync_d      = hsync_in;
    vsync_d      = vsync_in;
    frame_tick_d = tick_cond_c;
    if (!active_c) begin
      rgb_d = '0;
    end else if (hit_c) begin
      rgb_d = BOX_COLOR;
    end else begin
      rgb_d = bar_color_c;
    end
  end

  // Horizontal bounce, evaluated once per frame tick unless paused.
  always_comb begin
    box_x_d = box_x_q;
    dir_x_d = dir_x_q;
    if (frame_tick_q && !pause) begin
      if (dir_x_q == DIR_FWD) begin
        if ((box_x_q + BOX_W + STEP_W) > H_LIMIT) begin
          dir_x_d = DIR_REV;
          box_x_d = box_x_q - STEP_W;
        end else begin
          box_x_d = box_x_q + STEP_W;
        end
      end else begin
        if (box_x_q < STEP_W) begin
          dir_x_d = DIR_FWD;
          box_x_d = box_x_q + STEP_W;
        end else begin
          box_x_d = box_x_q - STEP_W;
        end
      end
    end
  end

  // Vertical bounce, independent of the horizontal axis.
  always_comb begin
    box_y_d = box_y_q;
    dir_y_d = dir_y_q;
    if (frame_tick_q && !pause) begin
      if (dir_y_q == DIR_FWD) begin
        if ((box_y_q + BOX_W + STEP_W) > V_LIMIT) begin
          dir_y_d = DIR_REV;
          box_y_d = box_y_q - STEP_W;
        end else begin
          box_y_d = box_y_q + STEP_W;
        end
      end else begin
        if (box_y_q < STEP_W) begin
          dir_y_d = DIR_FWD;
          box_y_d = box_y_q + STEP_W;
        end else begin
          box_y_d = box_y_q - STEP_W;
        end
      end
    end
  end

  // Output registers; syncs idle high in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q        <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Sprite position and direction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= DIR_FWD;
      dir_y_q <= DIR_FWD;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign rgb        = rgb_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/vga_pixel_gen.md
# vga_pixel_gen

Pixel generator sitting directly downstream of the VGA timing controller. It consumes the controller's hcount, vcount, hsync and vsync and draws a fixed 8-bar colour background overlaid with a square sprite that bounces off the screen edges, moving once per frame. It drives registered 8-bit RGB (RRRGGGBB) plus syncs delayed to stay pixel-aligned with the colour.

## Interface
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- BOX_SIZE, 32: sprite edge length in pixels.
- STEP, 2: sprite displacement per frame per axis, in pixels.
- BOX_COLOR, 8'h92: sprite colour.
- clk  in  1  pixel clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hcount  in  10  horizontal position from the timing controller.
- vcount  in  10  vertical position from the timing controller.
- hsync_in  in  1  horizontal sync from the controller (active-low).
- vsync_in  in  1  vertical sync from the controller (active-low).
- pause  in  1  high freezes sprite motion.
- hsync_out  out  1  hsync_in delayed one clock.
- vsync_out  out  1  vsync_in delayed one clock.
- rgb  out  8  pixel colour, RRRGGGBB.
- frame_tick  out  1  one-clock pulse at the start of vertical blanking.

## Operation
- Reset (rst=0, asynchronous): rgb=0, hsync_out=1, vsync_out=1, frame_tick=0, box_x=0, box_y=0, dir_x=right, dir_y=down.
- Active region: hcount < H_ACTIVE and vcount < V_ACTIVE. Outside it, rgb=0.
- Sprite hit: box_x <= hcount < box_x+BOX_SIZE and box_y <= vcount < box_y+BOX_SIZE. Compare in 11 bits. A hit gives rgb=BOX_COLOR.
- Background: bar index = hcount[8:6], giving 64-pixel bars. Index 0..7 maps to FF, FC, 1F, 1C, E3, E0, 03, 00. The index wraps, so bars 8 and 9 repeat colours 0 and 1.
- Priority: blanking, then sprite, then bar.
- Frame tick condition: hcount==0 and vcount==V_ACTIVE. frame_tick is registered from it.
- Motion update, per axis, on the clock where frame_tick=1 and pause=0:
  - Moving right/down and pos+BOX_SIZE+STEP > limit: reverse direction, pos <= pos-STEP.
  - Moving left/up and pos < STEP: reverse direction, pos <= pos+STEP.
  - Otherwise pos <= pos±STEP.
  - limit is H_ACTIVE for x and V_ACTIVE for y. Arithmetic is 11-bit and never wraps.
- Both axes are evaluated independently. A simultaneous corner hit reverses both directions on the same tick.
- With pause=1, frame_tick still pulses and the position and direction are held.

## Timing
- rgb, hsync_out and vsync_out have 1-clock latency from hcount, vcount, hsync_in and vsync_in. Colour and sync stay aligned.
- frame_tick is asserted the clock after the input condition is sampled.
- Position changes the clock after frame_tick. This falls inside vertical blanking, so there is no tearing.
- Reset asserted mid-frame: all outputs go to their reset values immediately. On deassertion, the first registered output is computed from the inputs sampled on the first rising edge.
- hcount/vcount values beyond 799/524 are treated as blanking; there is no special handling.

## Test plan
- Reset check: hold rst=0 with arbitrary inputs -> rgb=00, hsync_out=1, vsync_out=1, frame_tick=0. Release, then drive hcount=5, vcount=5 -> rgb=92 on the next clock.
- Background and blanking:
  - hcount=40, vcount=100 -> rgb=FF.
  - hcount=130 -> 1F.
  - hcount=600 (index 1) -> FC.
  - hcount=700 or vcount=500 -> 00.
  - Each value appears one clock after it is applied.
- Sync alignment: toggle hsync_in and vsync_in on arbitrary cycles -> hsync_out and vsync_out reproduce them exactly one clock later.
- Bounce:
  - 1 tick (hcount=0, vcount=480) -> sprite at (2,2).
  - After 224 ticks, y=448. Tick 225 -> y=446, moving up.
  - After 304 ticks, x=608. Tick 305 -> x=606, moving left. Verify by probing the sprite edges via rgb.
- Pause: pause=1 over 10 ticks -> frame_tick pulses 10 times and the sprite position is unchanged. Release pause, one tick -> position advances by STEP.
- Async reset mid-operation: assert rst between clock edges mid-line with the sprite at (40,40) -> outputs clear without a clock edge, and the sprite returns to (0,0), moving right/down.
